regfile_sb: RTL and testbench

- Parametrised successor to the CPU's single-write, dual-read register file, for the dynamic pipeline.
- Adds a per-register pending-write scoreboard: issue stage marks destination busy; writeback clears it.
- Read ports return data plus a busy flag so the hazard unit stalls without its own tracking.
- Debug taps expose a contiguous window of registers to the board display logic.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_pend_cnt.sv | 51 +++++
 rtl/regfile_sb.sv | 119 +++++++++++
 tb/tb_regfile_sb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_pkg : shared constants, pending-count type and helper for regfile_sb|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 2;
  localparam int REG_ZERO   = 0;

  typedef logic [CNT_W_DEF-1:0] pend_cnt_t;

  function automatic int max_cnt(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/regfile_pend_cnt.sv
// +----------------------------------------------------------------------------+
// | regfile_pend_cnt : per-register outstanding-write counter, saturating at max|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_pend_cnt
  import regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_busy,
  output logic o_full,
  output logic o_drain
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(max_cnt(CNT_W));
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over dec; an issue in the clearing cycle still lands.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = i_inc ? C_CNT_ONE : '0;
    end else if (i_inc && !i_dec && cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end else if (i_dec && !i_inc && cnt_q != '0) begin
      cnt_d = cnt_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_busy  = (cnt_q != '0);
  assign o_full  = (cnt_q == C_CNT_MAX);
  assign o_drain = i_dec && !i_inc && !i_clr && (cnt_q == C_CNT_ONE);

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// +----------------------------------------------------------------------------+
// | regfile_sb : 1W/2R register file with pending-write scoreboard, debug taps  |
// | Optional macro REGFILE_BYPASS_EN: same-cycle writeback-to-read forwarding.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DBG_BASE = 6,
  parameter int DBG_N    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  output logic [DATA_W-1:0]       rd_data_a,
  output logic                    rd_busy_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic [DATA_W-1:0]       rd_data_b,
  output logic                    rd_busy_b,
  input  logic                    wb_we,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    iss_v,
  input  logic [ADDR_W-1:0]       iss_rd,
  output logic                    iss_rdy,
  input  logic                    flush,
  output logic                    wb_err,
  output logic [DBG_N*DATA_W-1:0] dbg_data
);

  localparam int C_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]  mem_q [C_DEPTH];
  logic [DATA_W-1:0]  mem_d [C_DEPTH];
  logic               wb_err_q;
  logic               wb_err_d;
  logic [C_DEPTH-1:0] busy_w;
  logic [C_DEPTH-1:0] full_w;
  logic [C_DEPTH-1:0] drain_w;
  logic               wb_hit;
  logic               iss_acc;

  assign wb_hit  = wb_we && (wb_addr != C_ZERO);
  assign iss_rdy = !full_w[iss_rd] || (wb_we && (wb_addr == iss_rd) && !flush);
  assign iss_acc = iss_v && iss_rdy && (iss_rd != C_ZERO);

  // Register 0 has no counter: permanently idle and never full.
  assign busy_w[0]  = 1'b0;
  assign full_w[0]  = 1'b0;
  assign drain_w[0] = 1'b0;

  for (genvar i = 1; i < C_DEPTH; i++) begin : g_cnt
    regfile_pend_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (iss_acc && (iss_rd == ADDR_W'(i))),
      .i_dec   (wb_hit && !flush && (wb_addr == ADDR_W'(i)) && busy_w[i]),
      .i_clr   (flush),
      .o_busy  (busy_w[i]),
      .o_full  (full_w[i]),
      .o_drain (drain_w[i])
    );
  end

  always_comb begin
    mem_d = mem_q;
    if (wb_hit) mem_d[wb_addr] = wb_data;
  end

  assign wb_err_d = wb_err_q || (wb_hit && !flush && !busy_w[wb_addr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_DEPTH; i++) mem_q[i] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

`ifdef REGFILE_BYPASS_EN
  logic byp_a;
  logic byp_b;

  assign byp_a     = ena && wb_hit && (wb_addr == rd_addr_a);
  assign byp_b     = ena && wb_hit && (wb_addr == rd_addr_b);
  assign rd_data_a = !ena ? '0 : (byp_a ? wb_data : mem_q[rd_addr_a]);
  assign rd_data_b = !ena ? '0 : (byp_b ? wb_data : mem_q[rd_addr_b]);
  assign rd_busy_a = busy_w[rd_addr_a] && !(byp_a && drain_w[rd_addr_a]);
  assign rd_busy_b = busy_w[rd_addr_b] && !(byp_b && drain_w[rd_addr_b]);
`else
  logic unused_drain;

  assign unused_drain = ^drain_w;
  assign rd_data_a    = ena ? mem_q[rd_addr_a] : '0;
  assign rd_data_b    = ena ? mem_q[rd_addr_b] : '0;
  assign rd_busy_a    = busy_w[rd_addr_a];
  assign rd_busy_b    = busy_w[rd_addr_b];
`endif

  for (genvar k = 0; k < DBG_N; k++) begin : g_dbg
    assign dbg_data[k*DATA_W +: DATA_W] = mem_q[DBG_BASE + k];
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_sb : directed self-checking bench for regfile_sb                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_sb;

  logic         clk;
  logic         rst;
  logic         ena;
  logic [4:0]   rd_addr_a;
  logic [31:0]  rd_data_a;
  logic         rd_busy_a;
  logic [4:0]   rd_addr_b;
  logic [31:0]  rd_data_b;
  logic         rd_busy_b;
  logic         wb_we;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         iss_v;
  logic [4:0]   iss_rd;
  logic         iss_rdy;
  logic         flush;
  logic         wb_err;
  logic [159:0] dbg_data;

  int nvec = 0;
  int nerr = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_busy_a (rd_busy_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .rd_busy_b (rd_busy_b),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .iss_v     (iss_v),
    .iss_rd    (iss_rd),
    .iss_rdy   (iss_rdy),
    .flush     (flush),
    .wb_err    (wb_err),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    iss_v = 1'b0; iss_rd = '0; flush = 1'b0; ena = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    tick();
    idle();
    iss_v = 1'b1; iss_rd = 5'd8;
    tick();
    idle();
    iss_rd = 5'd8; rd_addr_a = 5'd7; rd_addr_b = 5'd8;
    #1;
    nvec++; if (rd_data_a !== 32'h1234) begin nerr++; $display("FAIL rst_pre_data: got %h want %h", rd_data_a, 32'h1234); end
    nvec++; if (rd_busy_b !== 1'b1) begin nerr++; $display("FAIL rst_pre_busy: got %b want 1", rd_busy_b); end
    #2;
    rst = 1'b1;
    #1;
    nvec++; if (rd_data_a !== 32'h0) begin nerr++; $display("FAIL rst_data: got %h want 0", rd_data_a); end
    nvec++; if (rd_busy_b !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", rd_busy_b); end
    nvec++; if (iss_rdy !== 1'b1) begin nerr++; $display("FAIL rst_iss_rdy: got %b want 1", iss_rdy); end
    nvec++; if (wb_err !== 1'b0) begin nerr++; $display("FAIL rst_wb_err: got %b want 0", wb_err); end
    nvec++; if (dbg_data !== 160'h0) begin nerr++; $display("FAIL rst_dbg: got %h want 0", dbg_data); end
    rst = 1'b0;
  endtask

  task automatic test_r0_and_dbg();
    logic [159:0] exp_dbg;
    logic [31:0]  val;
    tick();
    do_reset();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    idle();
    iss_v = 1'b1; iss_rd = 5'd0;
    #1;
    nvec++; if (iss_rdy !== 1'b1) begin nerr++; $display("FAIL r0_iss_rdy: got %b want 1", iss_rdy); end
    tick();
    idle();
    rd_addr_a = 5'd0;
    #1;
    nvec++; if (rd_data_a !== 32'h0) begin nerr++; $display("FAIL r0_data: got %h want 0", rd_data_a); end
    nvec++; if (rd_busy_a !== 1'b0) begin nerr++; $display("FAIL r0_busy: got %b want 0", rd_busy_a); end
    nvec++; if (wb_err !== 1'b0) begin nerr++; $display("FAIL r0_wb_err: got %b want 0", wb_err); end
    exp_dbg = '0;
    for (int k = 0; k < 5; k++) begin
      val = 32'hA + 32'(k);
      wb_we = 1'b1; wb_addr = 5'(6 + k); wb_data = val;
      tick();
      idle();
      exp_dbg[k*32 +: 32] = val;
      nvec++; if (dbg_data !== exp_dbg) begin nerr++; $display("FAIL dbg_r%0d: got %h want %h", 6 + k, dbg_data, exp_dbg); end
    end
  endtask

  task automatic test_saturate();
    tick();
    do_reset();
    rd_addr_a = 5'd5;
    for (int n = 0; n < 3; n++) begin
      iss_v = 1'b1; iss_rd = 5'd5;
      #1;
      nvec++; if (iss_rdy !== 1'b1) begin nerr++; $display("FAIL sat_rdy_%0d: got %b want 1", n, iss_rdy); end
      tick();
    end
    iss_v = 1'b1; iss_rd = 5'd5;
    #1;
    nvec++; if (iss_rdy !== 1'b0) begin nerr++; $display("FAIL sat_full_rdy: got %b want 0", iss_rdy); end
    tick();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    #1;
    nvec++; if (iss_rdy !== 1'b1) begin nerr++; $display("FAIL sat_wb_rdy: got %b want 1", iss_rdy); end
    tick();
    wb_we = 1'b0;
    #1;
    nvec++; if (iss_rdy !== 1'b0) begin nerr++; $display("FAIL sat_still_full: got %b want 0", iss_rdy); end
    idle();
    rd_addr_a = 5'd5;
    for (int n = 0; n < 3; n++) begin
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h60 + 32'(n);
      tick();
      idle();
      rd_addr_a = 5'd5;
      #1;
      nvec++; if (rd_busy_a !== (n < 2)) begin nerr++; $display("FAIL sat_drain_%0d: got %b want %b", n, rd_busy_a, n < 2); end
    end
    nvec++; if (wb_err !== 1'b0) begin nerr++; $display("FAIL sat_wb_err: got %b want 0", wb_err); end
    nvec++; if (rd_data_a !== 32'h62) begin nerr++; $display("FAIL sat_data: got %h want %h", rd_data_a, 32'h62); end
  endtask

  task automatic test_wb_err();
    tick();
    do_reset();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    tick();
    idle();
    rd_addr_a = 5'd9;
    #1;
    nvec++; if (rd_data_a !== 32'h99) begin nerr++; $display("FAIL err_data: got %h want %h", rd_data_a, 32'h99); end
    nvec++; if (rd_busy_a !== 1'b0) begin nerr++; $display("FAIL err_busy: got %b want 0", rd_busy_a); end
    nvec++; if (wb_err !== 1'b1) begin nerr++; $display("FAIL err_set: got %b want 1", wb_err); end
    iss_v = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9A;
    tick();
    idle();
    tick();
    nvec++; if (wb_err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", wb_err); end
  endtask

  task automatic test_flush();
    tick();
    do_reset();
    iss_v = 1'b1; iss_rd = 5'd3;
    tick();
    tick();
    flush = 1'b1;
    #1;
    nvec++; if (iss_rdy !== 1'b1) begin nerr++; $display("FAIL fl_rdy: got %b want 1", iss_rdy); end
    tick();
    idle();
    rd_addr_a = 5'd3;
    #1;
    nvec++; if (rd_busy_a !== 1'b1) begin nerr++; $display("FAIL fl_busy: got %b want 1", rd_busy_a); end
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    tick();
    idle();
    rd_addr_a = 5'd3;
    #1;
    nvec++; if (rd_busy_a !== 1'b0) begin nerr++; $display("FAIL fl_wb_busy: got %b want 0", rd_busy_a); end
    nvec++; if (wb_err !== 1'b0) begin nerr++; $display("FAIL fl_wb_err: got %b want 0", wb_err); end
    iss_v = 1'b1; iss_rd = 5'd2;
    tick();
    idle();
    flush = 1'b1; wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    tick();
    idle();
    rd_addr_b = 5'd2;
    #1;
    nvec++; if (rd_data_b !== 32'h22) begin nerr++; $display("FAIL flwb_data: got %h want %h", rd_data_b, 32'h22); end
    nvec++; if (rd_busy_b !== 1'b0) begin nerr++; $display("FAIL flwb_busy: got %b want 0", rd_busy_b); end
    nvec++; if (wb_err !== 1'b0) begin nerr++; $display("FAIL flwb_err: got %b want 0", wb_err); end
  endtask

  task automatic test_read_timing();
    tick();
    do_reset();
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111;
    tick();
    wb_data = 32'hDEAD; rd_addr_a = 5'd4;
    #1;
    nvec++; if (rd_data_a !== (BYP ? 32'hDEAD : 32'h1111)) begin nerr++; $display("FAIL byp_same: got %h want %h", rd_data_a, BYP ? 32'hDEAD : 32'h1111); end
    tick();
    idle();
    rd_addr_a = 5'd4;
    #1;
    nvec++; if (rd_data_a !== 32'hDEAD) begin nerr++; $display("FAIL byp_next: got %h want %h", rd_data_a, 32'hDEAD); end
    ena = 1'b0; rd_addr_b = 5'd4; wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hBEEF;
    #1;
    nvec++; if (rd_data_a !== 32'h0) begin nerr++; $display("FAIL ena_a: got %h want 0", rd_data_a); end
    nvec++; if (rd_data_b !== 32'h0) begin nerr++; $display("FAIL ena_b: got %h want 0", rd_data_b); end
    tick();
    idle();
    iss_v = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444; rd_addr_a = 5'd4;
    #1;
    nvec++; if (rd_busy_a !== !BYP) begin nerr++; $display("FAIL byp_busy: got %b want %b", rd_busy_a, !BYP); end
    tick();
    idle();
    rd_addr_a = 5'd4;
    #1;
    nvec++; if (rd_busy_a !== 1'b0) begin nerr++; $display("FAIL byp_busy_next: got %b want 0", rd_busy_a); end
    nvec++; if (rd_data_a !== 32'h4444) begin nerr++; $display("FAIL byp_data_next: got %h want %h", rd_data_a, 32'h4444); end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = '0;
    rd_addr_b = '0;
    idle();
    #12;
    rst = 1'b0;
    tick();
    test_reset();
    test_r0_and_dbg();
    test_saturate();
    test_wb_err();
    test_flush();
    test_read_timing();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
